// File: rtl/booth_wallace_mul_pipe_if.sv
// Operand/result handshake bundle for booth_wallace_mul_pipe.
// slave = multiplier side, master = issuing stage / consumer side.
interface booth_wallace_mul_pipe_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 a_signed;
   logic                 b_signed;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic [TAG_W-1:0]     out_tag;

   modport slave (
      input  in_valid, a, b, a_signed, b_signed, in_tag, out_ready,
      output in_ready, out_valid, p, out_tag
   );

   modport master (
      output in_valid, a, b, a_signed, b_signed, in_tag, out_ready,
      input  in_ready, out_valid, p, out_tag
   );
endinterface

// File: rtl/booth_wallace_mul_pipe.sv
// Four-stage radix-4 Booth / Wallace-tree multiplier with valid/ready, tag and flush.
// Optional MUL_OPCNT_EN adds a 32-bit count of delivered results (op_count).
module booth_wallace_mul_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
`ifdef MUL_OPCNT_EN
   output logic [31:0] op_count,
`endif
   booth_wallace_mul_pipe_if.slave bus
);
   localparam int unsigned EW  = WIDTH + 2;
   localparam int unsigned PW  = 2 * WIDTH;
   localparam int unsigned NPP = EW / 2;

   logic              s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
   logic [TAG_W-1:0]  s1_tag_q, s2_tag_q, s3_tag_q, out_tag_q;
   logic [EW-1:0]     a_ext_d, b_ext_d, s1_a_q, s1_b_q;
   logic [PW-1:0]     pp_d [NPP];
   logic [PW-1:0]     pp_q [NPP];
   logic [PW-1:0]     sum_d, carry_d, sum_q, carry_q, p_q;
   logic              adv;
`ifdef MUL_OPCNT_EN
   logic [31:0]       op_count_q;
   assign op_count = op_count_q;
`endif

   // Whole pipe moves together; bubbles are held in place during a stall.
   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.p         = p_q;
   assign bus.out_tag   = out_tag_q;

   assign a_ext_d = {{2{bus.a_signed & bus.a[WIDTH-1]}}, bus.a};
   assign b_ext_d = {{2{bus.b_signed & bus.b[WIDTH-1]}}, bus.b};

   // Radix-4 Booth recoding of b; negation folded into each row as ~m + 1.
   always_comb begin : booth_pp
      logic [PW-1:0] a_sx;
      logic [PW-1:0] mag;
      logic [EW:0]   b_z;
      logic [2:0]    sel;
      logic          neg;
      a_sx = PW'($signed(s1_a_q));
      b_z  = {s1_b_q, 1'b0};
      mag  = '0;
      neg  = 1'b0;
      sel  = '0;
      for (int i = 0; i < int'(NPP); i++) begin
         sel = b_z[2*i +: 3];
         mag = '0;
         neg = 1'b0;
         case (sel)
            3'b001, 3'b010: mag = a_sx;
            3'b011:         mag = a_sx << 1;
            3'b100: begin   mag = a_sx << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_sx; neg = 1'b1; end
            default:        mag = '0;
         endcase
         pp_d[i] = (neg ? (~mag + PW'(1)) : mag) << (2*i);
      end
   end

   // Wallace reduction: each level compresses groups of three rows into two.
   always_comb begin : csa_tree
      logic [PW-1:0] row [NPP];
      logic [PW-1:0] nxt [NPP];
      int            n;
      int            m;
      row = pp_q;
      n   = int'(NPP);
      m   = 0;
      for (int r = 0; r < int'(NPP); r++) nxt[r] = '0;
      for (int lvl = 0; lvl < int'(NPP); lvl++) begin
         if (n > 2) begin
            for (int r = 0; r < int'(NPP); r++) nxt[r] = '0;
            m = 0;
            for (int g = 0; g < int'(NPP) / 3; g++) begin
               if (3*g + 2 < n) begin
                  nxt[m]   = row[3*g] ^ row[3*g+1] ^ row[3*g+2];
                  nxt[m+1] = ((row[3*g] & row[3*g+1]) | (row[3*g] & row[3*g+2]) |
                              (row[3*g+1] & row[3*g+2])) << 1;
                  m = m + 2;
               end
            end
            for (int r = 0; r < int'(NPP); r++) begin
               if (r >= 3 * (n / 3) && r < n) begin
                  nxt[m] = row[r];
                  m = m + 1;
               end
            end
            row = nxt;
            n   = m;
         end
      end
      sum_d   = row[0];
      carry_d = row[1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s3_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         p_q         <= '0;
         out_tag_q   <= '0;
`ifdef MUL_OPCNT_EN
         op_count_q  <= '0;
`endif
      end else begin
         if (adv) begin
            s1_a_q   <= a_ext_d;
            s1_b_q   <= b_ext_d;
            s1_tag_q <= bus.in_tag;
            pp_q     <= pp_d;
            s2_tag_q <= s1_tag_q;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            s3_tag_q <= s2_tag_q;
            // p holds its last value across no-op cycles.
            if (s3_valid_q) begin
               p_q       <= sum_q + carry_q;
               out_tag_q <= s3_tag_q;
            end
         end
         if (flush) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
         end else if (adv) begin
            s1_valid_q  <= bus.in_valid;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
         end
`ifdef MUL_OPCNT_EN
         if (out_valid_q && bus.out_ready) op_count_q <= op_count_q + 32'd1;
`endif
      end
   end
endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Randomised and directed checks of booth_wallace_mul_pipe at WIDTH=32 and WIDTH=8.
module tb_booth_wallace_mul_pipe;
   localparam int unsigned TW = 4;

   typedef struct {
      logic [63:0]   p;
      logic [TW-1:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst, flush;
   int   n_chk = 0, n_fail = 0;
   exp_t q32[$], q8[$];
   logic hs32, hs8, acc8;
   logic [63:0]   last_p32;
   logic [TW-1:0] last_tag32;
   int   tot32 = 0, tot8 = 0;

   always #5 clk = ~clk;

   booth_wallace_mul_pipe_if #(.WIDTH(32), .TAG_W(TW)) b32 ();
   booth_wallace_mul_pipe_if #(.WIDTH(8),  .TAG_W(TW)) b8 ();
`ifdef MUL_OPCNT_EN
   logic [31:0] cnt32, cnt8;
`endif

   booth_wallace_mul_pipe #(.WIDTH(32), .TAG_W(TW)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
`ifdef MUL_OPCNT_EN
      .op_count(cnt32),
`endif
      .bus(b32));

   booth_wallace_mul_pipe #(.WIDTH(8), .TAG_W(TW)) dut8 (
      .clk(clk), .rst(rst), .flush(flush),
`ifdef MUL_OPCNT_EN
      .op_count(cnt8),
`endif
      .bus(b8));

   // Reference: extend each operand to its mathematical value, multiply, keep 2*w bits.
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic as, input logic bs);
      longint ea, eb, pr;
      logic [63:0] r;
      ea = longint'({32'd0, a});
      eb = longint'({32'd0, b});
      if (as && a[w-1]) ea = ea - (longint'(1) << w);
      if (bs && b[w-1]) eb = eb - (longint'(1) << w);
      pr = ea * eb;
      r  = 64'(pr);
      if (w < 32) r = r & ((64'd1 << (2*w)) - 64'd1);
      return r;
   endfunction

   task automatic drive32(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic as, input logic bs, input logic [TW-1:0] tag);
      b32.in_valid = v; b32.a = a; b32.b = b;
      b32.a_signed = as; b32.b_signed = bs; b32.in_tag = tag;
   endtask

   // One cycle on the 32-bit pipe: score the handshake, track acceptance, advance to next negedge.
   task automatic step32();
      logic acc, hs;
      exp_t e;
      #1;
      acc = b32.in_valid && b32.in_ready && !flush && !rst;
      hs  = b32.out_valid && b32.out_ready;
      hs32 = hs;
      if (hs) begin
         last_p32 = b32.p; last_tag32 = b32.out_tag;
         n_chk++;
         if (q32.size() == 0) begin
            n_fail++;
            $display("FAIL w32_unexpected: got p=%h tag=%h, expected no result", b32.p, b32.out_tag);
         end else begin
            e = q32.pop_front();
            if (b32.p !== e.p || b32.out_tag !== e.tag) begin
               n_fail++;
               $display("FAIL w32_result: got p=%h tag=%h, expected p=%h tag=%h",
                        b32.p, b32.out_tag, e.p, e.tag);
            end
         end
      end
      if (rst) begin tot32 = 0; tot8 = 0; end
      else if (hs) tot32++;
      if (flush || rst) q32.delete();
      if (acc) q32.push_back('{ref_mul(32, b32.a, b32.b, b32.a_signed, b32.b_signed), b32.in_tag});
      @(negedge clk);
   endtask

   task automatic step8();
      logic hs;
      exp_t e;
      #1;
      acc8 = b8.in_valid && b8.in_ready && !flush && !rst;
      hs   = b8.out_valid && b8.out_ready;
      hs8  = hs;
      if (hs) begin
         n_chk++;
         if (q8.size() == 0) begin
            n_fail++;
            $display("FAIL w8_unexpected: got p=%h tag=%h, expected no result", b8.p, b8.out_tag);
         end else begin
            e = q8.pop_front();
            if (b8.p !== e.p[15:0] || b8.out_tag !== e.tag) begin
               n_fail++;
               $display("FAIL w8_result: got p=%h tag=%h, expected p=%h tag=%h",
                        b8.p, b8.out_tag, e.p[15:0], e.tag);
            end
         end
      end
      if (!rst && hs) tot8++;
      if (flush || rst) q8.delete();
      if (acc8) q8.push_back('{ref_mul(8, {24'd0, b8.a}, {24'd0, b8.b}, b8.a_signed, b8.b_signed),
                               b8.in_tag});
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      drive32(1'b0, '0, '0, 1'b0, 1'b0, '0); b32.out_ready = 1'b1;
      b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.a_signed = 1'b0; b8.b_signed = 1'b0;
      b8.in_tag = '0; b8.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_chk += 3;
      if (b32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", b32.out_valid); end
      if (b32.p !== 64'd0) begin n_fail++; $display("FAIL reset_p: got %h, expected 0", b32.p); end
      if (b8.out_tag !== 4'd0) begin n_fail++; $display("FAIL reset_out_tag: got %h, expected 0", b8.out_tag); end
      rst = 1'b0; tot32 = 0; tot8 = 0;
      @(negedge clk);
      n_chk += 2;
      if (b32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready32: got %b, expected 1", b32.in_ready); end
      if (b8.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8: got %b, expected 1", b8.in_ready); end
   endtask

   task automatic test_directed();
      logic [31:0] da[5], db[5];
      logic        dsa[5], dsb[5];
      logic [63:0] dp[5];
      int          lat;
      da[0] = 32'hFFFFFFFF; db[0] = 32'h00000005; dsa[0] = 1; dsb[0] = 1; dp[0] = 64'hFFFFFFFFFFFFFFFB;
      da[1] = 32'hFFFFFFFF; db[1] = 32'hFFFFFFFF; dsa[1] = 0; dsb[1] = 0; dp[1] = 64'hFFFFFFFE00000001;
      da[2] = 32'h80000000; db[2] = 32'hFFFFFFFF; dsa[2] = 1; dsb[2] = 0; dp[2] = 64'h8000000080000000;
      da[3] = 32'h80000000; db[3] = 32'h80000000; dsa[3] = 1; dsb[3] = 1; dp[3] = 64'h4000000000000000;
      da[4] = 32'h7FFFFFFF; db[4] = 32'h80000000; dsa[4] = 0; dsb[4] = 1; dp[4] = 64'hC000000080000000;
      b32.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive32(1'b1, da[k], db[k], dsa[k], dsb[k], 4'(k + 9));
         step32();
         b32.in_valid = 1'b0;
         lat = 0;
         for (int c = 1; c <= 8; c++) begin
            step32();
            if (hs32) begin lat = c; break; end
         end
         n_chk += 2;
         if (lat != 4) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d, expected 4", k, lat); end
         if (last_p32 !== dp[k] || last_tag32 !== 4'(k + 9)) begin
            n_fail++;
            $display("FAIL directed_value[%0d]: got p=%h tag=%h, expected p=%h tag=%h",
                     k, last_p32, last_tag32, dp[k], 4'(k + 9));
         end
      end
   endtask

   task automatic test_back_to_back();
      int t = 0, first = -1, last = -1, cnt = 0;
      b32.out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c < 8) drive32(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'(c));
         else b32.in_valid = 1'b0;
         step32();
         if (hs32) begin
            if (first < 0) first = t;
            last = t;
            cnt++;
         end
         t++;
      end
      n_chk += 2;
      if (cnt != 8) begin n_fail++; $display("FAIL b2b_count: got %0d, expected 8", cnt); end
      if (last - first != 7) begin n_fail++; $display("FAIL b2b_span: got %0d, expected 7", last - first); end
   endtask

   task automatic test_backpressure();
      logic [63:0]   hp;
      logic [TW-1:0] ht;
      b32.out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive32(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
         step32();
      end
      hp = b32.p; ht = b32.out_tag;
      for (int c = 0; c < 5; c++) begin
         drive32(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
         #1;
         n_chk += 2;
         if (b32.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, expected 0", b32.in_ready); end
         if (b32.p !== hp || b32.out_tag !== ht || b32.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got p=%h tag=%h v=%b, expected p=%h tag=%h v=1",
                     b32.p, b32.out_tag, b32.out_valid, hp, ht);
         end
         step32();
      end
      b32.in_valid = 1'b0; b32.out_ready = 1'b1;
      repeat (8) step32();
      n_chk++;
      if (q32.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, expected 0", q32.size()); end
   endtask

   // Three ops in flight plus one offered in the kill cycle; use_rst selects rst instead of flush.
   task automatic test_kill(input logic use_rst);
      int lat = 0;
      b32.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive32(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'(c + 1));
         step32();
      end
      drive32(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 4'hF);
      if (use_rst) rst = 1'b1; else flush = 1'b1;
      step32();
      rst = 1'b0; flush = 1'b0; b32.in_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         n_chk++;
         if (b32.out_valid !== 1'b0 || (use_rst && (b32.p !== 64'd0 || b32.out_tag !== 4'd0))) begin
            n_fail++;
            $display("FAIL kill_idle[%0d] rst=%b: got v=%b p=%h tag=%h, expected v=0",
                     c, use_rst, b32.out_valid, b32.p, b32.out_tag);
         end
         step32();
      end
      drive32(1'b1, 32'h12345678, 32'h9ABCDEF0, use_rst, 1'b1, 4'h6);
      step32();
      b32.in_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step32();
         if (hs32) begin lat = c; break; end
      end
      n_chk++;
      if (lat != 4) begin n_fail++; $display("FAIL kill_restart_latency rst=%b: got %0d, expected 4", use_rst, lat); end
   endtask

   task automatic test_random8();
      int issued = 0;
      for (int c = 0; c < 40000 && issued < 10000; c++) begin
         b8.in_valid  = ($urandom_range(0, 3) != 0);
         b8.a         = 8'($urandom);
         b8.b         = 8'($urandom);
         b8.a_signed  = 1'($urandom);
         b8.b_signed  = 1'($urandom);
         b8.in_tag    = 4'($urandom);
         b8.out_ready = ($urandom_range(0, 4) != 0);
         flush        = ($urandom_range(0, 499) == 0);
         step8();
         if (acc8) issued++;
      end
      flush = 1'b0; b8.in_valid = 1'b0; b8.out_ready = 1'b1;
      repeat (8) step8();
      n_chk += 2;
      if (issued != 10000) begin n_fail++; $display("FAIL rand_issued: got %0d, expected 10000", issued); end
      if (q8.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending, expected 0", q8.size()); end
   endtask

`ifdef MUL_OPCNT_EN
   task automatic test_op_count();
      n_chk += 2;
      if (cnt32 !== 32'(tot32)) begin n_fail++; $display("FAIL opcnt32: got %0d, expected %0d", cnt32, tot32); end
      if (cnt8 !== 32'(tot8)) begin n_fail++; $display("FAIL opcnt8: got %0d, expected %0d", cnt8, tot8); end
   endtask
`endif

   initial begin
      rst = 1'b1; flush = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_kill(1'b0);
      test_kill(1'b1);
      test_random8();
`ifdef MUL_OPCNT_EN
      test_op_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/booth_wallace_mul_pipe.md
Name: booth_wallace_mul_pipe

Overview:
Parametrised, fully pipelined radix-4 Booth / Wallace-tree multiplier for the RISC-V PE execute path.
- Successor to the fixed 32-bit signed multiplier; supports any even WIDTH and per-operand signed/unsigned mode, covering MUL/MULH/MULHSU/MULHU.
- Adds a valid/ready handshake with backpressure, a per-op tag passed alongside the data, and a synchronous flush.
- Returns the full 2*WIDTH-bit product; the issuing stage selects the low or high half.

Parameters:
WIDTH, 32, operand width; must be even and at least 4.
TAG_W, 4, width of the opaque tag carried with each operation (rd index, ROB slot, etc).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
flush  in  1  synchronous; kills every in-flight op.
in_valid  in  1  operation offered.
in_ready  out  1  pipeline can accept an operation this cycle.
a  in  WIDTH  multiplicand.
b  in  WIDTH  multiplier.
a_signed  in  1  1 = a is two's complement, 0 = a is unsigned.
b_signed  in  1  1 = b is two's complement, 0 = b is unsigned.
in_tag  in  TAG_W  tag returned with the result.
out_valid  out  1  product is valid.
out_ready  in  1  consumer accepts the product.
p  out  2*WIDTH  product.
out_tag  out  TAG_W  tag of the product.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, p 0, out_tag 0. in_ready is 1 in the cycle after reset.
- Accept: an op is accepted when in_valid && in_ready.
- Pipeline stages (four, each with its own valid bit and tag register):
  - S1: capture the operands. Extend each to WIDTH+2 bits, sign-extending if its *_signed bit is 1, zero-extending otherwise.
  - S2: generate (WIDTH+2)/2 radix-4 Booth partial products, each sign-extended to 2*WIDTH bits, with the negate correction bit folded in. Register them.
  - S3: combinational 3:2 CSA tree reduces the partial products to a sum row and a carry row. Register both rows.
  - S4: carry-propagate add, truncated modulo 2^(2*WIDTH). Register the result into p.
- Latency: exactly 4 cycles from accept to out_valid when not stalled. Throughput is 1 op/cycle.
- Backpressure: advance = !out_valid || out_ready.
  - When advance is 0, every stage register holds, including bubbles (no bubble collapse).
  - in_ready = advance, combinational.
- Output stability: p and out_tag are stable while out_valid && !out_ready. They update only on advance.
- No-op cycles: when advance is 1 and no valid op reaches S4, out_valid drops to 0 and p keeps its last value.
- Flush: all valid bits clear at the next edge, including out_valid. An op offered in the same cycle as flush is discarded, even if in_valid && in_ready. The data registers need not clear.
- Reset mid-operation: identical to flush, and p/out_tag also go to 0.
- Ordering: results emerge strictly in acceptance order, each with its accompanying tag.
- Edge values: the most negative operand in either mode must be exact. The WIDTH+2 extension guarantees no Booth overflow.

Optional Feature:
Macro MUL_OPCNT_EN.
- Defined: adds output port op_count, 32 bits.
  - Increments by 1 on each out_valid && out_ready.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by rst; not cleared by flush.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- WIDTH=32, signed×signed, a=0xFFFFFFFF (-1), b=0x00000005, out_ready=1 -> 4 cycles later p=0xFFFFFFFFFFFFFFFB with the tag echoed.
- Unsigned×unsigned: a=b=0xFFFFFFFF -> p=0xFFFFFFFE00000001. Signed×unsigned (MULHSU): a=0x80000000, b=0xFFFFFFFF -> p=0x8000000080000000.
- Back-to-back: 8 consecutive ops with tags 0..7 -> 8 results on 8 consecutive cycles, in order, matching a reference model.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, p/out_tag stable; release -> no op lost or duplicated.
- Flush with 3 ops in flight plus an op offered that cycle -> out_valid stays 0 until a new op completes 4 cycles after its accept. Repeat with rst asserted mid-stream -> same, and p=0.
- WIDTH=8, random signed/unsigned mode combos with 10k random ops -> all match the model. With MUL_OPCNT_EN defined, op_count equals the number of handshaken results.
